// File: rtl/ddfs_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddfs_pkg : shared widths, default tuning words and quarter-wave table maths
// Revision : 1.0
// ----------------------------------------------------------------------------
package ddfs_pkg;

  localparam int SINE_W = 16;
  localparam int TRI_W  = 17;
  localparam int LUT_AW = 10;
  localparam int QTAB_N = 257;

  localparam logic [31:0] DEF_SINE_FTW = 32'd4294967;
  localparam logic [31:0] DEF_TRI_FTW  = 32'd85899346;

  typedef logic signed [3:0]        pwm3_t;
  typedef logic signed [SINE_W-1:0] sine_t;
  typedef logic signed [TRI_W-1:0]  tri_t;

  localparam pwm3_t PWM3_POS  = 4'sd1;
  localparam pwm3_t PWM3_ZERO = 4'sd0;
  localparam pwm3_t PWM3_NEG  = -4'sd1;

  // Elaboration-time only: round(32767*sin(2*pi*n/1024)) via a Taylor series,
  // which stays exact to well below half an LSB over the first quadrant.
  function automatic logic [SINE_W-2:0] quarter_sample(input int n);
    real x;
    real term;
    real acc;
    x    = 2.0 * 3.14159265358979323846 * real'(n) / 1024.0;
    term = x;
    acc  = x;
    for (int j = 1; j < 12; j++) begin
      term = -term * x * x / real'((2 * j) * (2 * j + 1));
      acc  = acc + term;
    end
    return (SINE_W-1)'($rtoi(32767.0 * acc + 0.5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddfs_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddfs_if : output bundle of the DDFS (sine, carrier and SPWM gate signals)
// Revision : 1.0
// ----------------------------------------------------------------------------
interface ddfs_if;
  import ddfs_pkg::*;

  sine_t Sine_out;
  tri_t  Tri_out;
  logic  PWM_1;
  logic  PWM_2;
  pwm3_t PWM_3;

  modport master (
    output Sine_out,
    output Tri_out,
    output PWM_1,
    output PWM_2,
    output PWM_3
  );

  modport slave (
    input Sine_out,
    input Tri_out,
    input PWM_1,
    input PWM_2,
    input PWM_3
  );

endinterface
`default_nettype wire

// File: rtl/ddfs_sine_lut.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddfs_sine_lut : 10-bit phase to registered 16-bit signed sine sample
// Revision : 1.0
// ----------------------------------------------------------------------------
module ddfs_sine_lut
  import ddfs_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [LUT_AW-1:0] addr,
  output sine_t             sample
);

  logic [SINE_W-2:0] qtab [0:QTAB_N-1];

  for (genvar n = 0; n < QTAB_N; n++) begin : g_qtab
    localparam logic [SINE_W-2:0] QV = quarter_sample(n);
    assign qtab[n] = QV;
  end

  logic [8:0]        idx;
  logic [SINE_W-1:0] mag;
  sine_t             folded;

  // Odd quadrants read the table mirrored (256-i), which is why it holds 257 entries.
  always_comb begin
    idx    = addr[8] ? (9'd256 - {1'b0, addr[7:0]}) : {1'b0, addr[7:0]};
    mag    = {1'b0, qtab[idx]};
    folded = addr[9] ? -$signed(mag) : $signed(mag);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample <= '0;
    end else begin
      sample <= folded;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddfs_top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddfs_top : free-running DDFS sine + triangle carrier with SPWM comparators
// Revision : 1.0
// ----------------------------------------------------------------------------
module ddfs_top
  import ddfs_pkg::*;
#(
  parameter int                 PHASE_W  = 32,
  parameter logic [PHASE_W-1:0] SINE_FTW = PHASE_W'(DEF_SINE_FTW),
  parameter logic [PHASE_W-1:0] TRI_FTW  = PHASE_W'(DEF_TRI_FTW)
) (
  input logic    clk,
  input logic    resetn,
  ddfs_if.master bus
);

  logic [PHASE_W-1:0] s_acc;
  logic [PHASE_W-1:0] t_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_acc <= '0;
      t_acc <= '0;
    end else begin
      s_acc <= s_acc + SINE_FTW;
      t_acc <= t_acc + TRI_FTW;
    end
  end

  sine_t sine_reg;

  ddfs_sine_lut u_lut (
    .clk    (clk),
    .resetn (resetn),
    .addr   (s_acc[PHASE_W-1 -: LUT_AW]),
    .sample (sine_reg)
  );

  logic [15:0] tri_p;
  logic [15:0] tri_fold;
  tri_t        tri_next;
  tri_t        tri_reg;

  // Fold the sawtooth phase into 0..32767, then stretch it to the signed carrier.
  always_comb begin
    tri_p    = t_acc[PHASE_W-1 -: 16];
    tri_fold = tri_p[15] ? (16'hFFFF - tri_p) : tri_p;
    tri_next = $signed({tri_fold, 1'b0}) - 17'sd32768;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tri_reg <= '0;
    end else begin
      tri_reg <= tri_next;
    end
  end

  tri_t  sine_ext;
  tri_t  sine_neg;
  logic  lead_a;
  logic  lead_b;
  pwm3_t pwm3_next;

  always_comb begin
    sine_ext = $signed({sine_reg[SINE_W-1], sine_reg});
    sine_neg = -sine_ext;
    lead_a   = (sine_ext > tri_reg);
    lead_b   = (sine_neg > tri_reg);
    if (lead_a == lead_b) begin
      pwm3_next = PWM3_ZERO;
    end else if (lead_a) begin
      pwm3_next = PWM3_POS;
    end else begin
      pwm3_next = PWM3_NEG;
    end
  end

  logic  pwm1_reg;
  logic  pwm2_reg;
  pwm3_t pwm3_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm1_reg <= 1'b0;
      pwm2_reg <= 1'b0;
      pwm3_reg <= PWM3_ZERO;
    end else begin
      pwm1_reg <= lead_a;
      pwm2_reg <= lead_b;
      pwm3_reg <= pwm3_next;
    end
  end

  assign bus.Sine_out = sine_reg;
  assign bus.Tri_out  = tri_reg;
  assign bus.PWM_1    = pwm1_reg;
  assign bus.PWM_2    = pwm2_reg;
  assign bus.PWM_3    = pwm3_reg;

endmodule
`default_nettype wire

// File: tb/tb_ddfs_top.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ddfs_top : two DDFS instances (default and unit-step tuning) vs. a model
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ddfs_top;
  import ddfs_pkg::*;

  localparam real         PI           = 3.14159265358979323846;
  localparam logic [31:0] LUT_SINE_FTW = 32'd4194304;
  localparam logic [31:0] LUT_TRI_FTW  = 32'd65536;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  ddfs_if bus_def ();
  ddfs_if bus_lut ();

  ddfs_top dut_def (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_def)
  );

  ddfs_top #(
    .PHASE_W  (32),
    .SINE_FTW (LUT_SINE_FTW),
    .TRI_FTW  (LUT_TRI_FTW)
  ) dut_lut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_lut)
  );

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) k <= 0;
    else         k <= k + 1;
  end

  function automatic logic [31:0] phase_at(input logic [31:0] ftw, input int n);
    logic [63:0] prod;
    prod = 64'(n) * 64'(ftw);
    return prod[31:0];
  endfunction

  function automatic int sine_of_addr(input int a);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(a) / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int sine_at(input logic [31:0] ftw, input int kk);
    if (kk == 0) return 0;
    return sine_of_addr(int'(phase_at(ftw, kk - 1) >> 22));
  endfunction

  function automatic int tri_at(input logic [31:0] ftw, input int kk);
    int p;
    int q;
    if (kk == 0) return 0;
    p = int'(phase_at(ftw, kk - 1) >> 16);
    q = (p < 32768) ? p : 65535 - p;
    return 2 * q - 32768;
  endfunction

  task automatic pwm_model(input int s, input int t, output int l1, output int l2, output int p3);
    l1 = (s > t) ? 1 : 0;
    l2 = (-s > t) ? 1 : 0;
    p3 = l1 - l2;
  endtask

  task automatic pwm_at(input logic [31:0] sf, input logic [31:0] tf, input int kk,
                        output int l1, output int l2, output int p3);
    if (kk == 0) begin
      l1 = 0; l2 = 0; p3 = 0;
    end else begin
      pwm_model(sine_at(sf, kk - 1), tri_at(tf, kk - 1), l1, l2, p3);
    end
  endtask

  task automatic expect_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic [31:0] sf, input logic [31:0] tf,
                          input int kk, input int s, input int t,
                          input int p1, input int p2, input int p3);
    int e1, e2, e3;
    pwm_at(sf, tf, kk, e1, e2, e3);
    expect_eq({tag, ".sine"}, s, sine_at(sf, kk));
    expect_eq({tag, ".tri"}, t, tri_at(tf, kk));
    expect_eq({tag, ".pwm1"}, p1, e1);
    expect_eq({tag, ".pwm2"}, p2, e2);
    expect_eq({tag, ".pwm3"}, p3, e3);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    cmp_inst("def", DEF_SINE_FTW, DEF_TRI_FTW, k, int'(bus_def.Sine_out), int'(bus_def.Tri_out),
             int'(bus_def.PWM_1), int'(bus_def.PWM_2), int'(bus_def.PWM_3));
    cmp_inst("lut", LUT_SINE_FTW, LUT_TRI_FTW, k, int'(bus_lut.Sine_out), int'(bus_lut.Tri_out),
             int'(bus_lut.PWM_1), int'(bus_lut.PWM_2), int'(bus_lut.PWM_3));
  end

  task automatic check_zero(input string tag);
    expect_eq({tag, ".def_sine"}, int'(bus_def.Sine_out), 0);
    expect_eq({tag, ".def_tri"},  int'(bus_def.Tri_out), 0);
    expect_eq({tag, ".def_pwm"},  {bus_def.PWM_1, bus_def.PWM_2, bus_def.PWM_3}, 0);
    expect_eq({tag, ".lut_sine"}, int'(bus_lut.Sine_out), 0);
    expect_eq({tag, ".lut_tri"},  int'(bus_lut.Tri_out), 0);
    expect_eq({tag, ".lut_pwm"},  {bus_lut.PWM_1, bus_lut.PWM_2, bus_lut.PWM_3}, 0);
  endtask

  task automatic check_first_edge(input string tag);
    @(posedge clk); #1;
    expect_eq({tag, ".def_tri1"},  int'(bus_def.Tri_out), -32768);
    expect_eq({tag, ".def_sine1"}, int'(bus_def.Sine_out), 0);
    expect_eq({tag, ".lut_sine1"}, int'(bus_lut.Sine_out), 0);
  endtask

  int l1, l2, p3;
  int s, prev_s, prev_t;
  int s_max, s_min, m_max, m_min, m;
  int xings, pos_cnt, neg_cnt, overlap;
  int n_run, n_hold;

  initial begin
    // Model pins (hand-computed)
    expect_eq("model.q1", sine_of_addr(1), 201);
    expect_eq("model.q256", sine_of_addr(256), 32767);
    expect_eq("model.q768", sine_of_addr(768), -32767);
    pwm_model(1000, 0, l1, l2, p3);
    expect_eq("model.pwm_pos", {l1[0], l2[0], p3[3:0]}, {1'b1, 1'b0, 4'b0001});
    pwm_model(-1000, 0, l1, l2, p3);
    expect_eq("model.pwm_neg", {l1[0], l2[0], p3[3:0]}, {1'b0, 1'b1, 4'b1111});
    pwm_model(0, -5, l1, l2, p3);
    expect_eq("model.pwm_both", {l1[0], l2[0], p3[3:0]}, {1'b1, 1'b1, 4'b0000});

    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    resetn = 1'b1;

    // First run, then a 3 ns reset pulse between edges after posedge 500
    check_first_edge("run1");
    repeat (499) @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_zero("midrst");
    #2 resetn = 1'b1;
    check_first_edge("run2");
    repeat (300) @(posedge clk);

    // Randomly placed resets of random length
    repeat (4) begin
      n_run  = int'($urandom_range(20, 400));
      n_hold = int'($urandom_range(0, 3));
      repeat (n_run) @(posedge clk);
      #1 resetn = 1'b0;
      #1 check_zero("rndrst");
      repeat (n_hold) @(posedge clk);
      #($urandom_range(1, 2)) resetn = 1'b1;
    end

    // Final uninterrupted run: table/fold literals and default-run statistics
    s_max = -99999; s_min = 99999; m_max = -99999; m_min = 99999;
    xings = 0; pos_cnt = 0; neg_cnt = 0; overlap = 0; prev_s = 0; prev_t = 0;
    for (int c = 1; c <= 33000; c++) begin
      @(posedge clk); #1;
      case (c)
        1:     expect_eq("lut.sine@1", int'(bus_lut.Sine_out), 0);
        2:     expect_eq("lut.sine@2", int'(bus_lut.Sine_out), 201);
        3:     expect_eq("lut.sine@3", int'(bus_lut.Sine_out), 402);
        4:     expect_eq("lut.sine@4", int'(bus_lut.Sine_out), 603);
        257:   expect_eq("lut.sine@257", int'(bus_lut.Sine_out), 32767);
        513:   expect_eq("lut.sine@513", int'(bus_lut.Sine_out), 0);
        769:   expect_eq("lut.sine@769", int'(bus_lut.Sine_out), -32767);
        1026:  expect_eq("lut.sine@1026", int'(bus_lut.Sine_out), 201);
        32768: expect_eq("lut.tri@32768", int'(bus_lut.Tri_out), 32766);
        32770: expect_eq("lut.tri@32770", int'(bus_lut.Tri_out), 32764);
        default: ;
      endcase
      if (c == 2) begin
        expect_eq("lut.tri@2", int'(bus_lut.Tri_out), -32766);
        expect_eq("def.tri@2", int'(bus_def.Tri_out), -30148);
        expect_eq("def.sine@2", int'(bus_def.Sine_out), 201);
      end
      if (c <= 10000) begin
        s = int'(bus_def.Sine_out);
        m = sine_at(DEF_SINE_FTW, c);
        if (s > s_max) s_max = s;
        if (s < s_min) s_min = s;
        if (m > m_max) m_max = m;
        if (m < m_min) m_min = m;
        if (c > 1 && prev_s < 0 && s >= 0) xings++;
        if (c > 1 && bus_def.PWM_1 && bus_def.PWM_2 && prev_t >= 0) overlap++;
        if (c > 1000 && c <= 2000) begin
          if (bus_def.PWM_3 == 4'sd1)  pos_cnt++;
          if (bus_def.PWM_3 == -4'sd1) neg_cnt++;
        end
        prev_s = s;
        prev_t = int'(bus_def.Tri_out);
      end
    end

    expect_eq("def.peak", s_max, m_max);
    expect_eq("def.min", s_min, m_min);
    expect_eq("def.peak_near_full", (s_max >= 32700) ? 1 : 0, 1);
    expect_eq("def.min_near_full", (s_min <= -32700) ? 1 : 0, 1);
    expect_eq("def.rising_crossings", xings, 9);
    expect_eq("def.overlap_tri_ge0", overlap, 0);
    expect_eq("def.duty_pos_in_range", (pos_cnt >= 288 && pos_cnt <= 348) ? 1 : 0, 1);
    expect_eq("def.duty_neg_in_range", (neg_cnt >= 288 && neg_cnt <= 348) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
